// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the MEM-stage data RAM: access
//               size and FSM state enums, misalignment check, load extension.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size as carried on i_size
  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_e;

  // Handshake FSM states
  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_RESP = 2'b10
  } mem_state_e;

  // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
  localparam int C_CNT_W = 4;

  // A half must sit on an even byte, a word on a multiple of four;
  // the illegal size code always faults.
  function automatic logic mem_misaligned(input mem_size_e size,
                                          input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return |addr_lo;
      default:  return 1'b1;
    endcase
  endfunction

  // Pick the addressed lane(s) out of a stored word and extend to 32 bits.
  // Word loads pass through untouched, so is_unsigned has no effect there.
  function automatic logic [31:0] mem_load_extend(input logic [31:0] word,
                                                  input mem_size_e   size,
                                                  input logic [1:0]  addr_lo,
                                                  input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: return {{24{~is_unsigned & b[7]}}, b};
      MEM_HALF: return {{16{~is_unsigned & h[15]}}, h};
      MEM_WORD: return word;
      default:  return 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_merge
// Description : Byte-enable generation and store-lane merge. Replicates the
//               right-aligned store data across the word and substitutes the
//               enabled lanes into the current word contents.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_merge
  import mem_pkg::*;
(
  input  mem_size_e   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic [3:0]  o_be,
  output logic [31:0] o_merged
);

  logic [31:0] w_wdata_rep;

  // Byte enables and lane-replicated store data for the requested size
  always_comb begin
    o_be        = 4'b0000;
    w_wdata_rep = i_wdata;
    case (i_size)
      MEM_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        w_wdata_rep = {4{i_wdata[7:0]}};
      end
      MEM_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{i_wdata[15:0]}};
      end
      MEM_WORD: o_be = 4'b1111;
      default:  o_be = 4'b0000;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign o_merged[8*g +: 8] = o_be[g] ? w_wdata_rep[8*g +: 8] : i_old[8*g +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/mem_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_ram
// Description : MEM-stage data memory. Byte/half/word loads with sign or zero
//               extension, byte-lane stores, misalignment faults and a
//               req/ready/rvalid handshake with WAIT_CYCLES wait states.
//               Optional spy ports mem_addr/mem_data exist only when the
//               macro MEM_DATA_SPY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_ram
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int IDX_W       = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
`ifdef MEM_DATA_SPY_EN
  ,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data
`endif
);

  localparam logic [C_CNT_W-1:0] C_WAIT = C_CNT_W'(WAIT_CYCLES);

  mem_state_e         r_state;
  mem_state_e         w_state_nxt;
  logic [C_CNT_W-1:0] r_count;
  logic [31:0]        r_mem [DEPTH];

  logic [31:0] r_hold_rdata;
  logic        r_hold_mis;

  mem_size_e        w_size;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lo;
  logic [31:0]      w_old;
  logic             w_mis;
  logic             w_accept;
  logic             w_store;
  logic [3:0]       w_be;
  logic [31:0]      w_merged;
  logic [31:0]      w_new_rdata;
  logic [31:0]      w_resp_rdata;
  logic             w_resp_mis;
  logic             w_resp_nxt;

  // Upper address bits beyond the array are deliberately ignored (wrap)
  logic w_unused_addr;
  assign w_unused_addr = ^i_addr[31:IDX_W+2];

  assign w_size   = mem_size_e'(i_size);
  assign w_idx    = i_addr[IDX_W+1:2];
  assign w_lo     = i_addr[1:0];
  assign w_old    = r_mem[w_idx];
  assign w_mis    = mem_misaligned(w_size, w_lo);
  assign w_accept = i_req && o_ready;
  assign w_store  = w_accept && i_we && !w_mis && (|w_be);

  mem_lane_merge u_merge (
    .i_size    (w_size),
    .i_addr_lo (w_lo),
    .i_wdata   (i_wdata),
    .i_old     (w_old),
    .o_be      (w_be),
    .o_merged  (w_merged)
  );

  // Loads read pre-edge contents; stores and faults return zero data
  assign w_new_rdata  = (i_we || w_mis) ? 32'h0
                                        : mem_load_extend(w_old, w_size, w_lo, i_unsigned);
  // With no wait states the response leaves on the accept edge itself
  assign w_resp_rdata = w_accept ? w_new_rdata : r_hold_rdata;
  assign w_resp_mis   = w_accept ? w_mis       : r_hold_mis;
  assign w_resp_nxt   = (w_state_nxt == MEM_RESP);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= MEM_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state and ready; ready whenever a new request can be taken
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    case (r_state)
      MEM_IDLE, MEM_RESP: begin
        o_ready = 1'b1;
        if (w_accept) w_state_nxt = (C_WAIT != '0) ? MEM_WAIT : MEM_RESP;
        else          w_state_nxt = MEM_IDLE;
      end
      MEM_WAIT: begin
        if (r_count == C_CNT_W'(1)) w_state_nxt = MEM_RESP;
      end
      default: w_state_nxt = MEM_IDLE;
    endcase
  end

  // Wait counter: loaded on accept, counts down while waiting
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              r_count <= '0;
    else if (w_accept)           r_count <= C_WAIT;
    else if (r_state == MEM_WAIT) r_count <= r_count - C_CNT_W'(1);
  end

  // Storage array; cleared as a whole by reset, stores commit on accept
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_store) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Response payload captured on accept and held through the wait states
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hold_rdata <= '0;
      r_hold_mis   <= 1'b0;
    end else if (w_accept) begin
      r_hold_rdata <= w_new_rdata;
      r_hold_mis   <= w_mis;
    end
  end

  // Response outputs: valid for exactly the RESP cycle, zero otherwise
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rvalid     <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_rvalid     <= w_resp_nxt;
      o_rdata      <= w_resp_nxt ? w_resp_rdata : '0;
      o_misaligned <= w_resp_nxt ? w_resp_mis   : 1'b0;
    end
  end

`ifdef MEM_DATA_SPY_EN
  logic [31:0] r_hold_addr;
  logic [31:0] r_hold_data;
  logic [31:0] r_spy_addr;
  logic [31:0] r_spy_data;
  logic [31:0] w_new_data;

  // Spy data: merged store word, extended load data, or zero on a fault
  assign w_new_data = w_mis ? 32'h0 : (i_we ? w_merged : w_new_rdata);

  // Spy payload held alongside the response payload
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_addr <= i_addr;
      r_hold_data <= w_new_data;
    end
  end

  // Spy outputs follow o_rvalid
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_spy_addr <= '0;
      r_spy_data <= '0;
    end else begin
      r_spy_addr <= w_resp_nxt ? (w_accept ? i_addr     : r_hold_addr) : '0;
      r_spy_data <= w_resp_nxt ? (w_accept ? w_new_data : r_hold_data) : '0;
    end
  end

  assign mem_addr = r_spy_addr;
  assign mem_data = r_spy_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_data_ram
// Description : Self-checking bench for mem_data_ram. Two instances share
//               clock and reset: index 0 has no wait states, index 1 has
//               three. A byte-level memory model predicts every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_data_ram;

  localparam int W1 = 3;

  typedef struct {
    int          d;
    int          acc;
    int          due;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        we;
  logic [1:0]  sz;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        rdy0, rdy1, rv0, rv1, mis0, mis1;
  logic [31:0] rd0, rd1;
  logic        rdy [2];
  logic        rv  [2];
  logic        mis [2];
  logic [31:0] rd  [2];
`ifdef MEM_DATA_SPY_EN
  logic [31:0] sa0, sa1, sd0, sd1;
  logic [31:0] sa [2];
  logic [31:0] sd [2];
  assign sa[0] = sa0;
  assign sa[1] = sa1;
  assign sd[0] = sd0;
  assign sd[1] = sd1;
`endif
  assign rdy[0] = rdy0;
  assign rdy[1] = rdy1;
  assign rv[0]  = rv0;
  assign rv[1]  = rv1;
  assign mis[0] = mis0;
  assign mis[1] = mis1;
  assign rd[0]  = rd0;
  assign rd[1]  = rd1;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q [$];
  logic [7:0] mdl [2][1024];
  int   issued   [2];
  int   resp_cnt [2];
  int   last_cyc [2];
  logic [31:0] last_rdata [2];
  logic        last_mis   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_data_ram #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req[0]), .i_we(we), .i_size(sz),
    .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
    .o_ready(rdy0), .o_rvalid(rv0), .o_rdata(rd0), .o_misaligned(mis0)
`ifdef MEM_DATA_SPY_EN
    , .mem_addr(sa0), .mem_data(sd0)
`endif
  );

  mem_data_ram #(.DEPTH(256), .WAIT_CYCLES(W1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req[1]), .i_we(we), .i_size(sz),
    .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
    .o_ready(rdy1), .o_rvalid(rv1), .o_rdata(rd1), .o_misaligned(mis1)
`ifdef MEM_DATA_SPY_EN
    , .mem_addr(sa1), .mem_data(sd1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory, DEPTH*4 = 1024 bytes
  task automatic model(input int d, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int ba, nb, wb;
    logic [31:0] v;
    ba = int'(a[9:0]);
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    e.d = d; e.rdata = 0; e.data = 0; e.addr = a;
    e.mis = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    if (!e.mis) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mdl[d][ba+k] = wd[8*k +: 8];
        wb = ba - (ba % 4);
        e.data = {mdl[d][wb+3], mdl[d][wb+2], mdl[d][wb+1], mdl[d][wb]};
      end else begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (32'(mdl[d][ba+k]) << (8*k));
        if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        e.rdata = v;
        e.data  = v;
      end
    end
  endtask

  // Every cycle: compare each DUT against the oldest expected response
  always @(negedge clk) begin
    int idx;
    logic er;
    for (int d = 0; d < 2; d++) begin
      idx = -1;
      for (int i = 0; i < q.size(); i++) if (q[i].d == d && idx < 0) idx = i;
      er = (idx < 0) || (q[idx].due == cyc) || (q[idx].acc > cyc);
      chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(er));
      if (idx >= 0 && q[idx].due == cyc) begin
        chk($sformatf("rvalid%0d", d), 32'(rv[d]), 32'd1);
        chk($sformatf("rdata%0d", d), rd[d], q[idx].rdata);
        chk($sformatf("misaligned%0d", d), 32'(mis[d]), 32'(q[idx].mis));
`ifdef MEM_DATA_SPY_EN
        chk($sformatf("mem_addr%0d", d), sa[d], q[idx].addr);
        chk($sformatf("mem_data%0d", d), sd[d], q[idx].data);
`endif
        last_rdata[d] = rd[d];
        last_mis[d]   = mis[d];
        last_cyc[d]   = cyc;
        resp_cnt[d]++;
        q.delete(idx);
      end else begin
        chk($sformatf("idle_rvalid%0d", d), 32'(rv[d]), 32'd0);
        chk($sformatf("idle_rdata%0d", d), rd[d], 32'd0);
        chk($sformatf("idle_mis%0d", d), 32'(mis[d]), 32'd0);
`ifdef MEM_DATA_SPY_EN
        chk($sformatf("idle_spy%0d", d), sa[d] | sd[d], 32'd0);
`endif
      end
    end
  end

  // Issue one request to DUT d; returns after the accept edge
  task automatic op(input int d, input logic w, input logic [1:0] s, input logic u,
                    input logic [31:0] a, input logic [31:0] wd, output int acc);
    int n;
    exp_t e;
    we = w; sz = s; uns = u; addr = a; wdata = wd;
    req[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 64) begin @(negedge clk); n++; end
    if (!rdy[d]) begin
      total++; bad++;
      $display("FAIL accept_timeout%0d: got ready 0 want 1", d);
      req[d] = 1'b0;
      acc = -1;
      return;
    end
    model(d, w, s, u, a, wd, e);
    e.acc = cyc + 1;
    e.due = cyc + 1 + ((d == 0) ? 0 : W1);
    acc   = e.acc;
    q.push_back(e);
    issued[d]++;
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic wait_resp(input int d);
    int n;
    n = 0;
    #1;
    while (resp_cnt[d] < issued[d] && n < 40) begin @(negedge clk); #1; n++; end
    if (resp_cnt[d] < issued[d]) begin
      total++; bad++;
      $display("FAIL resp_timeout%0d: got %0d want %0d", d, resp_cnt[d], issued[d]);
    end
  endtask

  // One access plus hand-computed expectations for its response
  task automatic xact(input string name, input int d, input logic w, input logic [1:0] s,
                      input logic u, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis);
    int acc;
    op(d, w, s, u, a, wd, acc);
    wait_resp(d);
    chk({name, "_rdata"}, last_rdata[d], exp_rd);
    chk({name, "_mis"}, 32'(last_mis[d]), 32'(exp_mis));
    chk({name, "_latency"}, 32'(last_cyc[d] - acc), 32'((d == 0) ? 0 : W1));
  endtask

  task automatic reset_model();
    q.delete();
    for (int d = 0; d < 2; d++) begin
      issued[d] = resp_cnt[d];
      for (int i = 0; i < 1024; i++) mdl[d][i] = 8'h00;
    end
  endtask

  initial begin
    int a1, a2;
    rst_n = 1'b0; req = 2'b00; we = 1'b0; sz = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
    for (int d = 0; d < 2; d++) begin
      issued[d] = 0; resp_cnt[d] = 0; last_cyc[d] = 0; last_rdata[d] = '0; last_mis[d] = 1'b0;
    end
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rvalid", 32'(rv0), 32'd0);
    chk("reset_rdata", rd1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy0), 32'd1);

    // Byte store then word load
    xact("st_byte",  0, 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1'b0);
    xact("ld_word",  0, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hA500_0000, 1'b0);
    // Halfword extension
    xact("st_half",  0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_8001, 32'h0, 1'b0);
    xact("ld_hs",    0, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 32'hFFFF_8001, 1'b0);
    xact("ld_hu",    0, 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 32'h0000_8001, 1'b0);
    xact("ld_bs",    0, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0, 32'hFFFF_FF80, 1'b0);
    // Misalignment
    xact("ld_mis",   0, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1);
    xact("st_w4",    0, 1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'h1122_3344, 32'h0, 1'b0);
    xact("st_mis",   0, 1'b1, 2'd2, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0, 1'b1);
    xact("ld_w4",    0, 1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 32'h1122_3344, 1'b0);
    xact("ld_ill",   0, 1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b1);
    xact("ld_hodd",  0, 1'b0, 2'd1, 1'b1, 32'h0000_0203, 32'h0, 32'h0, 1'b1);
    // Wrap modulo DEPTH*4
    xact("st_wrap",  0, 1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h1234_5678, 32'h0, 1'b0);
    xact("ld_wrap",  0, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0);

    // Back-to-back store then load to the same word, one per cycle
    op(0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, a1);
    op(0, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, a2);
    wait_resp(0);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd1);
    chk("b2b_rdata", last_rdata[0], 32'hCAFE_F00D);

    // Wait states: second request accepted in the RESP cycle of the first
    xact("w_st",     1, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h55AA_55AA, 32'h0, 1'b0);
    op(1, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, a1);
    op(1, 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, a2);
    wait_resp(1);
    chk("wait_accept_gap", 32'(a2 - a1), 32'(W1 + 1));
    chk("wait_latency", 32'(last_cyc[1] - a2), 32'(W1));
    chk("wait_rdata", last_rdata[1], 32'h0000_55AA);

    // Reset while a response is pending in WAIT
    op(1, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, a1);
    #1;
    chk("pre_reset_ready", 32'(rdy1), 32'd0);
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("rst_rvalid", 32'(rv1), 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_mis", 32'(mis1), 32'd0);
    chk("rst_ready", 32'(rdy1), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_late_resp", 32'(resp_cnt[1] - issued[1]), 32'd0);
    xact("ld_after_rst1", 1, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0);
    xact("ld_after_rst0", 0, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0);

    repeat (4) @(negedge clk);
    #1;
    chk("all_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
